// File: rtl/seg_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan sequencer: digit widths,
// segment constants and FSM state encoding.
package seg_scan_ctrl_pkg;

  localparam int BCD_W = 4;
  localparam int SEG_W = 7;

  // Active-low patterns, bit 6 = segment a ... bit 0 = segment g
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_ZERO  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_scan_ctrl_bcd27seg.sv
// BCD to common-anode 7-segment decoder (active-low, a..g on bits 6..0).
// Codes 10..15 are shown dark.
module bcd27seg
  import seg_scan_ctrl_pkg::*;
(
  input  logic [BCD_W-1:0] bcd,
  output logic [SEG_W-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_ZERO;
      4'd1:    seg = 7'b1001111;
      4'd2:    seg = 7'b0010010;
      4'd3:    seg = 7'b0000110;
      4'd4:    seg = 7'b1001100;
      4'd5:    seg = 7'b0100100;
      4'd6:    seg = 7'b0100000;
      4'd7:    seg = 7'b0001111;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0000100;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Walks NDIG captured BCD digits (MSD first) through one shared decoder,
// updating one digit register per clock with optional leading-zero blanking.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int NDIG = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [BCD_W*NDIG-1:0] bcd_in,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [SEG_W*NDIG-1:0] seg_out
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t                state;
  logic [IW-1:0]         idx;
  logic [BCD_W*NDIG-1:0] shadow;
  logic                  lz_act;
  logic [BCD_W-1:0]      dig;
  logic [SEG_W-1:0]      dec;

  // The single decoder sits only on the register-input path of seg_out.
  assign dig = shadow[BCD_W*idx +: BCD_W];

  bcd27seg u_dec (
    .bcd (dig),
    .seg (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= IW'(NDIG-1);
      shadow  <= '0;
      lz_act  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      seg_out <= {NDIG{SEG_BLANK}};
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shadow <= bcd_in;
            lz_act <= blank_lz;
            idx    <= IW'(NDIG-1);
            busy   <= 1'b1;
            state  <= SCAN;
          end
        end
        SCAN: begin
          // Digit 0 is never blanked so an all-zero value still shows "0";
          // any non-zero code (including invalid ones) ends the blanking run.
          if (lz_act && (dig == '0) && (idx != '0)) begin
            seg_out[SEG_W*idx +: SEG_W] <= SEG_BLANK;
          end else begin
            seg_out[SEG_W*idx +: SEG_W] <= dec;
            lz_act <= 1'b0;
          end
          if (idx == '0) begin
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx - IW'(1);
          end
        end
        FIN: begin
          busy  <= 1'b0;
          idx   <= IW'(NDIG-1);
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized self-checking bench for seg_scan_ctrl (NDIG = 8) against a
// digit-level model of the display contents, busy and done.
module tb_seg_scan_ctrl;

  localparam int NDIG = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
  logic [31:0]   bcd_in;
  logic          blank_lz;
  logic          busy;
  logic          done;
  logic [55:0]   seg_out;

  int n_chk  = 0;
  int n_pass = 0;

  logic [55:0] disp;          // model of what the display should show
  logic [6:0]  pat [16];

  always #5 clk = ~clk;

  seg_scan_ctrl #(.NDIG(NDIG)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .bcd_in   (bcd_in),
    .blank_lz (blank_lz),
    .busy     (busy),
    .done     (done),
    .seg_out  (seg_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Final display for a value: blank leading zeros above digit 0 when asked.
  function automatic logic [55:0] model(input logic [31:0] v, input logic lz);
    logic [55:0] r;
    bit          leading;
    logic [3:0]  d;
    r = '0;
    leading = lz;
    for (int i = NDIG-1; i >= 0; i--) begin
      d = v[4*i +: 4];
      if (leading && d == 4'd0 && i != 0) r[7*i +: 7] = 7'h7F;
      else begin
        r[7*i +: 7] = pat[d];
        leading = 0;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load v at edge E, optionally inject a load at E+ld_at or a reset at E+rst_at.
  task automatic do_scan(input logic [31:0] v, input logic lz, input int ld_at, input int rst_at);
    logic [55:0] fin, exp;
    fin = model(v, lz);
    load = 1'b1; bcd_in = v; blank_lz = lz;
    tick();
    load = 1'b0; bcd_in = $urandom; blank_lz = 1'($urandom);
    chk("busy_after_load", busy, 1);
    chk("done_after_load", done, 0);
    chk("seg_hold_at_E", seg_out, disp);
    for (int k = 1; k <= NDIG + 1; k++) begin
      if (k == ld_at) begin load = 1'b1; bcd_in = $urandom; blank_lz = 1'($urandom); end
      if (k == rst_at) rst = 1'b1;
      tick();
      load = 1'b0;
      if (k == rst_at) begin
        rst = 1'b0;
        disp = {NDIG{7'h7F}};
        chk("rst_mid_seg", seg_out, disp);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", done, 0);
        tick();
        chk("rst_mid_no_done", done, 0);
        chk("rst_mid_idle", busy, 0);
        return;
      end
      exp = disp;
      for (int i = 0; i < NDIG; i++)
        if (i >= NDIG - k) exp[7*i +: 7] = fin[7*i +: 7];
      chk($sformatf("seg_E+%0d", k), seg_out, exp);
      chk($sformatf("done_E+%0d", k), done, (k == NDIG) ? 1 : 0);
      chk($sformatf("busy_E+%0d", k), busy, (k <= NDIG) ? 1 : 0);
    end
    disp = fin;
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] v;
    for (int i = 0; i < NDIG; i++)
      v[4*i +: 4] = ($urandom_range(0, 9) < 4) ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction

  initial begin
    pat = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
            7'b0000000, 7'b0000100, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    rst = 1'b1; load = 1'b0; bcd_in = '0; blank_lz = 1'b0;
    tick(); tick();
    rst = 1'b0;
    disp = {NDIG{7'h7F}};
    tick();
    chk("reset_seg", seg_out, {NDIG{7'h7F}});
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // Reset wins over a simultaneous load
    rst = 1'b1; load = 1'b1; bcd_in = 32'h12345678;
    tick();
    rst = 1'b0; load = 1'b0;
    tick();
    chk("rst_load_busy", busy, 0);
    chk("rst_load_seg", seg_out, {NDIG{7'h7F}});

    do_scan(32'h12345678, 1'b0, 0, 0);
    chk("dir_12345678", seg_out, {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                  7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000});
    do_scan(32'h00000405, 1'b1, 0, 0);
    chk("dir_405_lz", seg_out, {{5{7'h7F}}, 7'b1001100, 7'b0000001, 7'b0100100});
    do_scan(32'h00000000, 1'b1, 0, 0);
    chk("dir_zero_lz", seg_out, {{7{7'h7F}}, 7'b0000001});
    do_scan(32'h11111111, 1'b0, 3, 0);
    chk("dir_ignored_load", seg_out, {NDIG{7'b1001111}});
    do_scan(32'hA0000000, 1'b1, 0, 0);
    chk("dir_invalid_ends_lz", seg_out, {7'h7F, {7{7'b0000001}}});
    do_scan(32'h87654321, 1'b0, 0, 4);
    chk("dir_rst_dark", seg_out, {NDIG{7'h7F}});

    for (int n = 0; n < 40; n++) begin
      int ld_at, rst_at;
      ld_at  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, NDIG + 1)) : 0;
      rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, NDIG)) : 0;
      do_scan(rand_val(), 1'($urandom), ld_at, rst_at);
      if ($urandom_range(0, 2) == 0) begin
        tick();
        chk("idle_gap_hold", seg_out, disp);
        chk("idle_gap_done", done, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
